oled_pattern_gen: RTL and testbench

Parametrised, multi-mode test-pattern source for the SSD1331 OLED video path. Sits between the `oled_video` scan engine, which supplies pixel coordinates `x`, `y`, and that engine's `color` input. It provides four selectable patterns, 8-bit or 16-bit colour packing, and frame-synchronous horizontal scrolling. Mode changes take effect only at frame boundaries so the panel never tears.

---
 rtl/oled_pattern_gen_if.sv | 35 +++
 rtl/oled_pattern_gen.sv | 140 ++++++++++++++
 tb/tb_oled_pattern_gen.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_pattern_gen_if.sv
// Pixel-coordinate / colour bundle between oled_video
// and the pattern generator.
interface oled_pattern_gen_if #(
  parameter int C_x_bits     = 7,
  parameter int C_y_bits     = 6,
  parameter int C_color_bits = 8
);
  logic [C_x_bits-1:0]     x;
  logic [C_y_bits-1:0]     y;
  logic                    mode_next;
  logic                    scroll_en;
  logic [C_color_bits-1:0] color;
  logic [1:0]              mode;
  logic                    frame;

  modport master (
    output x,
    output y,
    output mode_next,
    output scroll_en,
    input  color,
    input  mode,
    input  frame
  );

  modport slave (
    input  x,
    input  y,
    input  mode_next,
    input  scroll_en,
    output color,
    output mode,
    output frame
  );
endinterface

// File: rtl/oled_pattern_gen.sv
// Multi-mode test-pattern source for the SSD1331 path:
// four patterns, frame-synchronous mode switch and scroll.
module oled_pattern_gen #(
  parameter int C_x_size          = 96,
  parameter int C_y_size          = 64,
  parameter int C_x_bits          = 7,
  parameter int C_y_bits          = 6,
  parameter int C_color_bits      = 8,
  parameter int C_square_log2     = 3,
  parameter int C_scroll_div_log2 = 2,
  parameter int C_mode_init       = 0
) (
  input  logic              clk,
  input  logic              reset,
  oled_pattern_gen_if.slave io
);

  localparam logic [C_x_bits-1:0] X_LAST =
    C_x_bits'(C_x_size - 1);
  localparam logic [C_y_bits-1:0] Y_LAST =
    C_y_bits'(C_y_size - 1);
  localparam logic [8:0] DIV_M9 =
    9'((1 << C_scroll_div_log2) - 1);
  localparam logic [7:0] DIV_MASK = DIV_M9[7:0];
  localparam logic [1:0] MODE_INIT = 2'(C_mode_init);

  logic [C_y_bits-1:0] y_prev;
  logic                btn_prev;
  logic                pending;
  logic [1:0]          mode_q;
  logic [7:0]          frame_cnt;
  logic [C_x_bits-1:0] scroll;

  logic                frame_tick;
  logic                btn_edge;
  logic                advance;
  logic                scroll_step;
  logic [C_x_bits-1:0] xs;
  logic [7:0]          xs8;
  logic [7:0]          y8;
  logic                chk;
  logic                border;
  logic [7:0]          r;
  logic [7:0]          g;
  logic [7:0]          b;
  logic [C_color_bits-1:0] pix;

  assign frame_tick = (y_prev == Y_LAST) &&
                      (io.y == '0);
  assign btn_edge   = io.mode_next && !btn_prev;
  assign advance    = pending || btn_edge;
  assign scroll_step =
    io.scroll_en &&
    ((frame_cnt & DIV_MASK) == DIV_MASK);

  assign xs  = io.x + scroll;
  // left-justify coordinates into 8-bit channel values
  assign xs8 = 8'({xs, 8'h00} >> C_x_bits);
  assign y8  = 8'({io.y, 8'h00} >> C_y_bits);

  assign chk = xs[C_square_log2] ^
               io.y[C_square_log2];

  assign border = (io.x == '0) ||
                  (io.x == X_LAST) ||
                  (io.y == '0) ||
                  (io.y == Y_LAST);

  always_comb begin
    r = 8'h00;
    g = 8'h00;
    b = 8'h00;
    unique case (1'b1)
      (mode_q == 2'd0): begin
        if (chk) begin
          r = {xs8[7:5], 5'b0};
          g = {xs8[7:5], 5'b0};
        end else begin
          r = {y8[7:5], 5'b0};
        end
      end
      (mode_q == 2'd1): begin
        r = {8{xs8[7]}};
        g = {8{xs8[6]}};
        b = {8{xs8[5]}};
      end
      (mode_q == 2'd2): begin
        r = xs8;
        g = y8;
        b = frame_cnt;
      end
      (mode_q == 2'd3): begin
        r = {8{border}};
        g = {8{border}};
        b = {8{border}};
      end
      default: ;
    endcase
  end

  generate
    if (C_color_bits == 16) begin : g_rgb565
      assign pix = {r[7:3], g[7:2], b[7:3]};
    end else begin : g_rgb332
      assign pix = {r[7:5], g[7:5], b[7:6]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      y_prev    <= '0;
      btn_prev  <= 1'b1;
      pending   <= 1'b0;
      mode_q    <= MODE_INIT;
      frame_cnt <= 8'd0;
      scroll    <= '0;
      io.frame  <= 1'b0;
      io.color  <= '0;
    end else begin
      y_prev   <= io.y;
      btn_prev <= io.mode_next;
      io.frame <= frame_tick;
      io.color <= pix;
      if (frame_tick) begin
        frame_cnt <= frame_cnt + 8'd1;
        if (advance) begin
          mode_q  <= mode_q + 2'd1;
          pending <= 1'b0;
        end
        if (scroll_step)
          scroll <= scroll + C_x_bits'(1);
      end else if (btn_edge) begin
        pending <= 1'b1;
      end
    end
  end

  assign io.mode = mode_q;

endmodule

// File: tb/tb_oled_pattern_gen.sv
// Scoreboard bench: default 8-bit instance plus a
// 16-bit instance starting in border mode.
module tb_oled_pattern_gen;

  localparam int S_CA = 0;
  localparam int S_MA = 1;
  localparam int S_FA = 2;
  localparam int S_SA = 3;
  localparam int S_CB = 4;
  localparam int S_MB = 5;
  localparam int S_NA = 6;

  typedef struct {
    int          due;
    int          sel;
    logic [15:0] exp;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  oled_pattern_gen_if #(
    .C_x_bits(7), .C_y_bits(6), .C_color_bits(8)
  ) ifa ();
  oled_pattern_gen_if #(
    .C_x_bits(7), .C_y_bits(6), .C_color_bits(16)
  ) ifb ();

  oled_pattern_gen dut_a (
    .clk(clk), .reset(reset), .io(ifa)
  );
  oled_pattern_gen #(
    .C_color_bits(16), .C_mode_init(3)
  ) dut_b (
    .clk(clk), .reset(reset), .io(ifb)
  );

  function automatic logic [15:0] actual(int sel);
    case (sel)
      S_CA: return {8'h00, ifa.color};
      S_MA: return {14'b0, ifa.mode};
      S_FA: return {15'b0, ifa.frame};
      S_SA: return {9'b0, dut_a.scroll};
      S_CB: return ifb.color;
      S_MB: return {14'b0, ifb.mode};
      S_NA: return {8'h00, dut_a.frame_cnt};
      default: return 16'hDEAD;
    endcase
  endfunction

  // monitor: compares every entry that has come due
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] a;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      a = actual(e.sel);
      checks++;
      if (a !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h",
                 e.name, a, e.exp);
      end
    end
  end

  task automatic expect_v(int sel, logic [15:0] v,
                          string name);
    exp_t e;
    e.due  = cyc + 1;
    e.sel  = sel;
    e.exp  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(int xv, int yv);
    ifa.x = 7'(xv);
    ifa.y = 6'(yv);
    ifb.x = 7'(xv);
    ifb.y = 6'(yv);
  endtask

  task automatic pre_frame(int xv);
    drive(xv, 63);
    tick();
    drive(xv, 0);
  endtask

  task automatic run_frames(int n, int xv);
    repeat (n) begin
      pre_frame(xv);
      tick();
      drive(xv, 10);
      tick();
    end
  endtask

  task automatic pulse();
    ifa.mode_next = 1'b1;
    tick();
    ifa.mode_next = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    ifa.mode_next = 1'b0;
    ifa.scroll_en = 1'b0;
    ifb.mode_next = 1'b0;
    ifb.scroll_en = 1'b0;
    drive(0, 0);
    tick();
    expect_v(S_CA, 16'h0000, "rst_color_a");
    expect_v(S_MA, 16'd0, "rst_mode_a");
    expect_v(S_FA, 16'd0, "rst_frame_a");
    expect_v(S_SA, 16'd0, "rst_scroll_a");
    expect_v(S_MB, 16'd3, "rst_mode_b");
    expect_v(S_CB, 16'h0000, "rst_color_b");
    tick();
    reset = 1'b0;

    drive(9, 0);
    expect_v(S_CA, 16'h00, "chk_x9");
    expect_v(S_CB, 16'hFFFF, "b_top_row");
    tick();
    drive(8, 0);
    expect_v(S_CA, 16'h00, "chk_x8");
    tick();
    drive(72, 0);
    expect_v(S_CA, 16'h90, "chk_x72");
    tick();
    drive(0, 30);
    expect_v(S_CA, 16'h00, "chk_x0_y30");
    expect_v(S_CB, 16'hFFFF, "b_left_col");
    tick();
    drive(50, 30);
    expect_v(S_CA, 16'h6C, "chk_x50_y30");
    expect_v(S_CB, 16'h0000, "b_inside");
    tick();
    drive(95, 63);
    expect_v(S_CA, 16'hE0, "chk_x95_y63");
    expect_v(S_CB, 16'hFFFF, "b_corner");
    tick();

    drive(95, 10);
    tick();
    ifa.mode_next = 1'b1;
    tick();
    ifa.mode_next = 1'b0;
    expect_v(S_MA, 16'd0, "midframe_hold");
    tick();
    ifa.mode_next = 1'b1;
    tick();
    ifa.mode_next = 1'b0;
    expect_v(S_MA, 16'd0, "two_edges_hold");
    tick();

    pre_frame(72);
    expect_v(S_FA, 16'd1, "frame_pulse");
    expect_v(S_MA, 16'd1, "mode_at_tick");
    expect_v(S_CA, 16'h90, "old_mode_color");
    tick();
    expect_v(S_FA, 16'd0, "frame_one_cycle");
    expect_v(S_MA, 16'd1, "collapsed_edges");
    expect_v(S_CA, 16'hE0, "new_mode_color");
    tick();

    drive(72, 63);
    tick();
    drive(72, 0);
    ifa.mode_next = 1'b1;
    expect_v(S_MA, 16'd2, "coincident_edge");
    expect_v(S_FA, 16'd1, "coincident_frame");
    tick();
    ifa.mode_next = 1'b0;
    drive(72, 10);
    tick();
    run_frames(1, 72);
    drive(40, 20);
    expect_v(S_MA, 16'd2, "pending_clear");
    expect_v(S_NA, 16'd3, "frame_cnt_3");
    expect_v(S_CA, 16'h48, "gradient");
    tick();

    run_frames(252, 0);
    drive(0, 0);
    expect_v(S_CA, 16'h03, "grad_fc255");
    tick();
    pre_frame(0);
    expect_v(S_CA, 16'h03, "grad_old_fc");
    expect_v(S_NA, 16'd0, "fc_wrap");
    tick();
    drive(0, 0);
    expect_v(S_CA, 16'h00, "grad_fc_wrap");
    tick();

    repeat (3) begin
      drive(0, 10);
      pulse();
      run_frames(1, 0);
    end
    drive(0, 10);
    expect_v(S_MA, 16'd1, "mode_wrap_to_1");
    tick();

    ifa.scroll_en = 1'b1;
    ifb.scroll_en = 1'b1;
    run_frames(8, 0);
    drive(0, 10);
    expect_v(S_SA, 16'd2, "scroll_8_frames");
    tick();
    ifa.scroll_en = 1'b0;
    ifb.scroll_en = 1'b0;
    run_frames(4, 0);
    drive(14, 10);
    expect_v(S_SA, 16'd2, "scroll_frozen");
    expect_v(S_CA, 16'h03, "bars_x14");
    tick();
    drive(95, 10);
    expect_v(S_CA, 16'hFC, "bars_x95");
    tick();
    drive(95, 63);
    expect_v(S_CA, 16'hFC, "bars_x95_y63");
    expect_v(S_CB, 16'hFFFF, "b_corner_scroll");
    tick();
    drive(50, 30);
    expect_v(S_CA, 16'h1F, "bars_x50");
    expect_v(S_CB, 16'h0000, "b_inside_scroll");
    expect_v(S_MB, 16'd3, "b_mode_stable");
    tick();

    drive(72, 63);
    ifa.mode_next = 1'b1;
    tick();
    reset = 1'b1;
    expect_v(S_CA, 16'h00, "midrst_color");
    expect_v(S_MA, 16'd0, "midrst_mode");
    expect_v(S_FA, 16'd0, "midrst_frame");
    expect_v(S_SA, 16'd0, "midrst_scroll");
    expect_v(S_NA, 16'd0, "midrst_fc");
    expect_v(S_MB, 16'd3, "midrst_mode_b");
    expect_v(S_CB, 16'h0000, "midrst_color_b");
    tick();
    reset = 1'b0;
    drive(72, 0);
    expect_v(S_FA, 16'd0, "no_tick_after_rst");
    expect_v(S_MA, 16'd0, "mode_after_rst");
    expect_v(S_CA, 16'h90, "color_after_rst");
    tick();
    drive(72, 10);
    tick();
    pre_frame(72);
    expect_v(S_FA, 16'd1, "tick_after_rst");
    expect_v(S_MA, 16'd0, "held_btn_no_edge");
    tick();
    ifa.mode_next = 1'b0;
    drive(72, 10);
    expect_v(S_FA, 16'd0, "frame_low_end");
    tick();

    repeat (3) tick();
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d left expected 0",
               sb.size());
      errors++;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
